spi_master_engine: RTL and testbench
====================================

# spi_master_engine

Byte-level SPI master (mode 0, MSB first) that sits directly downstream of `spi_controller` and drives the external SPI pins of the MachXO2 CPLD. `spi_controller` hands it one byte per valid/ready handshake, with a last flag that closes the chip-select frame. The engine returns each received byte on a one-cycle strobe. It runs from the 2.08 MHz internal oscillator clock.

## Interface
- `CLK_DIV`, default 1: SCLK half-period in `clock` cycles. Legal range 1..255. Default gives SCLK = 1.04 MHz.
- `DATA_WIDTH`, default 8: bits per transfer. Legal range 2..16.

- `clock`  in  1  system clock (osc_clk). All logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Top connects `switch0` directly.
- `tx_valid`  in  1  `spi_controller` offers a byte.
- `tx_ready`  out  1  engine accepts a byte on this cycle if `tx_valid`=1.
- `tx_data`  in  DATA_WIDTH  byte to transmit. Sampled only at accept.
- `tx_last`  in  1  byte closes the frame. Sampled only at accept.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` holds the byte just received.
- `rx_data`  out  DATA_WIDTH  received byte. Held until the next strobe.
- `busy`  out  1  high from accept until the engine returns to IDLE.
- `sclk`  out  1  SPI clock. Idles low.
- `mosi`  out  1  SPI data out.
- `miso`  in  1  SPI data in. The slave is on the same board; no synchroniser.
- `cs_n`  out  1  chip select, active low.

## Operation
- All outputs are registered. Reset values:
  - `cs_n`=1, `sclk`=0, `mosi`=0
  - `rx_valid`=0, `rx_data`=0
  - `busy`=0, `tx_ready`=1
  - state=IDLE
- States: IDLE, SETUP, SHIFT, WAIT, HOLD, GAP.
- IDLE: `tx_ready`=1. On accept:
  - latch `tx_data` into the shift register and `tx_last` into `last_q`
  - drive `mosi`=MSB, `cs_n`=0, `busy`=1, `tx_ready`=0
  - go to SETUP
- SETUP: wait CLK_DIV cycles (CS-to-first-edge setup), then go to SHIFT.
- SHIFT: toggle `sclk` every CLK_DIV cycles, 2×DATA_WIDTH half-periods in total.
  - Rising edge: sample `miso` into the shift register LSB.
  - Falling edge (except the final one): shift left and present the next bit on `mosi`.
  - After the final falling edge (`sclk` back at 0): load `rx_data`, pulse `rx_valid` for 1 cycle, then branch:
    - `last_q`=1: go to HOLD.
    - `last_q`=0: go to WAIT.
- WAIT: `cs_n` stays 0 and `tx_ready`=1. On accept, latch the new byte, drive its MSB on `mosi`, and go straight to SHIFT (no SETUP). WAIT has no timeout; `spi_controller` owns framing.
- HOLD: wait CLK_DIV cycles with `cs_n`=0, then set `cs_n`=1 and go to GAP.
- GAP: wait CLK_DIV cycles (minimum CS-high time), then go to IDLE and set `busy`=0.
- `tx_ready` is 0 in SETUP, SHIFT, HOLD and GAP. `tx_valid` in those states is ignored, not queued.
- There is no receive backpressure. The consumer must take `rx_data` on the `rx_valid` cycle.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously). The partial byte is discarded and no `rx_valid` is produced.

## Timing
- Accept edge = cycle 0.
- First byte of a frame: `sclk` first rises at cycle 2×CLK_DIV. `rx_valid` is high in cycle (2×DATA_WIDTH+1)×CLK_DIV.
- Continuation byte accepted in WAIT: `rx_valid` is high in cycle 2×DATA_WIDTH×CLK_DIV.
- `cs_n` rises CLK_DIV cycles after the last `rx_valid`. `tx_ready` returns CLK_DIV cycles after that.
- With defaults (CLK_DIV=1, DATA_WIDTH=8):
  - first-byte latency 17 cycles
  - continuation latency 16 cycles
  - single-byte frame: accept to IDLE = 19 cycles
- `mosi` changes only on falling `sclk` edges or while `sclk`=0 before the first edge, so it is stable for a full half-period around every rising edge.

## Structure
- Shared include `spi_defs.vh` holds:
  - state encodings (3-bit)
  - default CLK_DIV and DATA_WIDTH
- `spi_controller` uses the same include.
- One sub-module, `spi_clk_div`: a counter that emits a one-cycle `tick` every CLK_DIV cycles while `enable`=1, and clears when `enable`=0. Enable is asserted in SETUP, SHIFT, HOLD and GAP.
- Bit counter width is $clog2(2×DATA_WIDTH+1).

## Test plan
- Single-byte loopback, defaults:
  - stimulus: `miso` tied to `mosi`, send 0xA5 with `tx_last`=1
  - response: `rx_valid` at cycle 17 with `rx_data`=0xA5; 8 `sclk` pulses; `cs_n` low for cycles 0..17; `busy` low at cycle 19
- Three-byte frame:
  - stimulus: 0x01, 0x80, 0xFF; slave model returns 0x3C, 0xC3, 0x00
  - response: `cs_n` stays low throughout; `rx_valid` at cycles 17, 33+d, 49+d'; received bytes in order
- CLK_DIV=3:
  - stimulus: send 0x5A with `tx_last`=1
  - response: `sclk` period 6 cycles; `rx_valid` at cycle 51; `mosi` transitions only when `sclk`=0
- Backpressure:
  - stimulus: hold `tx_valid`=1 throughout a transfer
  - response: exactly one accept per byte; a second byte is accepted only in WAIT or IDLE
- Reset mid-byte:
  - stimulus: drive `reset` low during the 4th `sclk` pulse
  - response: `cs_n`=1, `sclk`=0, `busy`=0 immediately; no `rx_valid`; next transfer after reset is correct

Source files
------------

// File: rtl/spi_master_engine_pkg.sv
// =============================================================================
// spi_master_engine_pkg
// Shared state encodings and default parameters for the SPI master engine.
// Revision: 1.0
// =============================================================================
`default_nettype none

package spi_master_engine_pkg;

    localparam int c_DEFAULT_CLK_DIV    = 1;
    localparam int c_DEFAULT_DATA_WIDTH = 8;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_HOLD  = 3'd4;
    localparam logic [2:0] c_ST_GAP   = 3'd5;

    // The SCLK divider only runs in the timed states; WAIT and IDLE park it.
    function automatic logic f_div_enabled(input logic [2:0] st);
        return (st == c_ST_SETUP) || (st == c_ST_SHIFT) ||
               (st == c_ST_HOLD)  || (st == c_ST_GAP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clk_div.sv
// =============================================================================
// spi_clk_div
// Emits a one-cycle tick every CLK_DIV cycles while enabled; clears when idle.
// Revision: 1.0
// =============================================================================
`default_nettype none

module spi_clk_div #(
    parameter int CLK_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_enable,
    output logic o_tick
);

    localparam logic [7:0] c_TERM = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    assign o_tick = i_enable && (r_cnt == c_TERM);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!i_enable || (r_cnt == c_TERM)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_master_engine.sv
// =============================================================================
// spi_master_engine
// Byte-level SPI mode-0 master, MSB first, with valid/ready transmit handshake.
// Revision: 1.0
// =============================================================================
`default_nettype none

module spi_master_engine
    import spi_master_engine_pkg::*;
#(
    parameter int CLK_DIV    = c_DEFAULT_CLK_DIV,
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_last,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);

    localparam int                c_BCW       = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [c_BCW-1:0]  c_LAST_HALF = c_BCW'(2 * DATA_WIDTH - 1);

    logic [2:0]            r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_last_q;
    logic [c_BCW-1:0]      r_bit_cnt;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_cs_n;
    logic                  r_rx_valid;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_busy;
    logic                  r_tx_ready;

    logic w_accept;
    logic w_tick;

    assign w_accept = tx_valid && r_tx_ready;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clock    (clock),
        .reset    (reset),
        .i_enable (f_div_enabled(r_state)),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_shreg    <= '0;
            r_last_q   <= 1'b0;
            r_bit_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_busy     <= 1'b0;
            r_tx_ready <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_shreg    <= tx_data;
                        r_last_q   <= tx_last;
                        r_mosi     <= tx_data[DATA_WIDTH-1];
                        r_cs_n     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_tx_ready <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_state    <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    if (w_tick) begin
                        r_state <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_tick) begin
                        r_sclk    <= ~r_sclk;
                        r_bit_cnt <= r_bit_cnt + c_BCW'(1);
                        // Shifting on the rising edge keeps the next TX bit at the MSB.
                        if (!r_sclk) begin
                            r_shreg <= {r_shreg[DATA_WIDTH-2:0], miso};
                        end else if (r_bit_cnt == c_LAST_HALF) begin
                            r_rx_data  <= r_shreg;
                            r_rx_valid <= 1'b1;
                            r_bit_cnt  <= '0;
                            if (r_last_q) begin
                                r_state <= c_ST_HOLD;
                            end else begin
                                r_state    <= c_ST_WAIT;
                                r_tx_ready <= 1'b1;
                            end
                        end else begin
                            r_mosi <= r_shreg[DATA_WIDTH-1];
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (w_accept) begin
                        r_shreg    <= tx_data;
                        r_last_q   <= tx_last;
                        r_mosi     <= tx_data[DATA_WIDTH-1];
                        r_tx_ready <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_state    <= c_ST_SHIFT;
                    end
                end
                c_ST_HOLD: begin
                    if (w_tick) begin
                        r_cs_n  <= 1'b1;
                        r_state <= c_ST_GAP;
                    end
                end
                c_ST_GAP: begin
                    if (w_tick) begin
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_state    <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign busy     = r_busy;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign cs_n     = r_cs_n;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_engine.sv
// =============================================================================
// tb_spi_master_engine
// Directed self-checking bench for spi_master_engine (defaults and CLK_DIV=3).
// Revision: 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_master_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid, tx_last, miso;
    logic [7:0] tx_data;
    logic       tx_ready, rx_valid, busy, sclk, mosi, cs_n;
    logic [7:0] rx_data;

    logic       tx_valid3, tx_last3, miso3;
    logic [7:0] tx_data3;
    logic       tx_ready3, rx_valid3, busy3, sclk3, mosi3, cs_n3;
    logic [7:0] rx_data3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic       loop_mode  = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    int         base_fall  = 0;
    int         fall_cnt   = 0;
    int         slave_idx;
    logic [7:0] mosi_cap   = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mode-0 slave: bit k of the byte is driven after the k-th falling SCLK edge.
    always @(negedge sclk) fall_cnt <= fall_cnt + 1;
    always @(posedge sclk) mosi_cap <= {mosi_cap[6:0], mosi};
    assign slave_idx = fall_cnt - base_fall;
    always_comb begin
        if (loop_mode)
            miso = mosi;
        else if (slave_idx >= 0 && slave_idx < 8)
            miso = slave_byte[3'(7 - slave_idx)];
        else
            miso = 1'b0;
    end
    assign miso3 = mosi3;

    spi_master_engine dut (
        .clock(clk), .reset(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    spi_master_engine #(.CLK_DIV(3), .DATA_WIDTH(8)) dut3 (
        .clock(clk), .reset(rst_n), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
        .tx_data(tx_data3), .tx_last(tx_last3), .rx_valid(rx_valid3), .rx_data(rx_data3),
        .busy(busy3), .sclk(sclk3), .mosi(mosi3), .miso(miso3), .cs_n(cs_n3)
    );

    task automatic test_reset();
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        tx_valid3 = 1'b0; tx_data3 = 8'h00; tx_last3 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs_n, sclk, mosi, rx_valid, busy, tx_ready, rx_data} !== 14'b1_0_0_0_0_1_00000000) begin
            errors++;
            $display("FAIL reset_state: got %b, expected %b",
                     {cs_n, sclk, mosi, rx_valid, busy, tx_ready, rx_data}, 14'b1_0_0_0_0_1_00000000);
        end
        checks++;
        if ({cs_n3, sclk3, mosi3, rx_valid3, busy3, tx_ready3, rx_data3} !== 14'b1_0_0_0_0_1_00000000) begin
            errors++;
            $display("FAIL reset_state_div3: got %b, expected %b",
                     {cs_n3, sclk3, mosi3, rx_valid3, busy3, tx_ready3, rx_data3}, 14'b1_0_0_0_0_1_00000000);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int acc, rel, pulses, first_rise, rx_cnt, rx_at, cs_rise, busy_low;
        logic [7:0] rx_d;
        logic prev;
        pulses = 0; first_rise = -1; rx_cnt = 0; rx_at = -1; cs_rise = -1; busy_low = -1;
        rx_d = 8'h00; prev = 1'b0;
        loop_mode = 1'b1;
        tx_valid = 1'b1; tx_data = 8'hA5; tx_last = 1'b1;
        @(negedge clk);
        acc = cyc;
        tx_valid = 1'b0;
        checks++;
        if ({cs_n, busy, tx_ready, mosi, sclk} !== 5'b0_1_0_1_0) begin
            errors++;
            $display("FAIL single_accept: got %b, expected %b", {cs_n, busy, tx_ready, mosi, sclk}, 5'b01010);
        end
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            rel = cyc - acc;
            if (sclk && !prev) begin
                pulses++;
                if (first_rise < 0) first_rise = rel;
            end
            prev = sclk;
            if (rx_valid) begin rx_cnt++; rx_at = rel; rx_d = rx_data; end
            if (cs_n && cs_rise < 0) cs_rise = rel;
            if (!busy && busy_low < 0) busy_low = rel;
        end
        checks++;
        if (first_rise !== 2) begin errors++; $display("FAIL single_first_rise: got %0d, expected 2", first_rise); end
        checks++;
        if (pulses !== 8) begin errors++; $display("FAIL single_pulses: got %0d, expected 8", pulses); end
        checks++;
        if (rx_cnt !== 1 || rx_at !== 17) begin
            errors++; $display("FAIL single_rx_timing: got count %0d at %0d, expected 1 at 17", rx_cnt, rx_at);
        end
        checks++;
        if (rx_d !== 8'hA5) begin errors++; $display("FAIL single_rx_data: got %h, expected a5", rx_d); end
        checks++;
        if (mosi_cap !== 8'hA5) begin errors++; $display("FAIL single_mosi: got %h, expected a5", mosi_cap); end
        checks++;
        if (cs_rise !== 18) begin errors++; $display("FAIL single_cs_rise: got %0d, expected 18", cs_rise); end
        checks++;
        if (busy_low !== 19 || tx_ready !== 1'b1) begin
            errors++; $display("FAIL single_busy_low: got %0d ready %b, expected 19 ready 1", busy_low, tx_ready);
        end
    endtask

    task automatic test_frame();
        logic [7:0] txb [3];
        logic [7:0] slv [3];
        int         gap [3];
        int         lat, acc, rx_at;
        logic       cs_bad, got;
        txb = '{8'h01, 8'h80, 8'hFF};
        slv = '{8'h3C, 8'hC3, 8'h00};
        gap = '{0, 3, 0};
        cs_bad = 1'b0;
        loop_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                @(negedge clk);
                if (cs_n || !tx_ready) cs_bad = 1'b1;
            end
            tx_valid = 1'b1; tx_data = txb[i]; tx_last = (i == 2);
            slave_byte = slv[i]; base_fall = fall_cnt;
            @(negedge clk);
            acc = cyc;
            tx_valid = 1'b0;
            lat = (i == 0) ? 17 : 16;
            rx_at = -1; got = 1'b0;
            for (int k = 1; k <= 40 && !got; k++) begin
                @(negedge clk);
                if (cs_n) cs_bad = 1'b1;
                if (rx_valid) begin got = 1'b1; rx_at = cyc - acc; end
            end
            checks++;
            if (rx_at !== lat || rx_data !== slv[i]) begin
                errors++;
                $display("FAIL frame_byte%0d_rx: got %h at %0d, expected %h at %0d", i, rx_data, rx_at, slv[i], lat);
            end
            checks++;
            if (mosi_cap !== txb[i]) begin
                errors++; $display("FAIL frame_byte%0d_mosi: got %h, expected %h", i, mosi_cap, txb[i]);
            end
        end
        checks++;
        if (cs_bad !== 1'b0) begin errors++; $display("FAIL frame_cs_held: got cs break %b, expected 0", cs_bad); end
        @(negedge clk);
        checks++;
        if ({cs_n, busy} !== 2'b11) begin errors++; $display("FAIL frame_cs_rise: got %b, expected 11", {cs_n, busy}); end
        @(negedge clk);
        checks++;
        if ({busy, tx_ready} !== 2'b01) begin errors++; $display("FAIL frame_idle: got %b, expected 01", {busy, tx_ready}); end
        loop_mode = 1'b1;
    endtask

    task automatic test_clkdiv3();
        int acc, rel, pulses, first_rise, last_rise, rx_at, cs_rise, busy_low;
        logic prev_s, prev_m, mosi_bad, period_bad;
        logic [7:0] rx_d;
        pulses = 0; first_rise = -1; last_rise = -1; rx_at = -1; cs_rise = -1; busy_low = -1;
        prev_s = 1'b0; prev_m = mosi3; mosi_bad = 1'b0; period_bad = 1'b0; rx_d = 8'h00;
        tx_valid3 = 1'b1; tx_data3 = 8'h5A; tx_last3 = 1'b1;
        @(negedge clk);
        acc = cyc;
        tx_valid3 = 1'b0;
        for (int k = 0; k <= 62; k++) begin
            if (k > 0) @(negedge clk);
            rel = cyc - acc;
            if (mosi3 !== prev_m && sclk3) mosi_bad = 1'b1;
            prev_m = mosi3;
            if (sclk3 && !prev_s) begin
                pulses++;
                if (first_rise < 0) first_rise = rel;
                else if (rel - last_rise != 6) period_bad = 1'b1;
                last_rise = rel;
            end
            prev_s = sclk3;
            if (rx_valid3) begin rx_at = rel; rx_d = rx_data3; end
            if (cs_n3 && cs_rise < 0) cs_rise = rel;
            if (!busy3 && busy_low < 0) busy_low = rel;
        end
        checks++;
        if (first_rise !== 6 || period_bad || pulses !== 8) begin
            errors++;
            $display("FAIL div3_sclk: got first %0d pulses %0d period_err %b, expected 6 8 0", first_rise, pulses, period_bad);
        end
        checks++;
        if (rx_at !== 51 || rx_d !== 8'h5A) begin
            errors++; $display("FAIL div3_rx: got %h at %0d, expected 5a at 51", rx_d, rx_at);
        end
        checks++;
        if (mosi_bad !== 1'b0) begin errors++; $display("FAIL div3_mosi_stable: got %b, expected 0", mosi_bad); end
        checks++;
        if (cs_rise !== 54 || busy_low !== 57) begin
            errors++; $display("FAIL div3_end: got cs %0d busy %0d, expected 54 57", cs_rise, busy_low);
        end
    endtask

    task automatic test_back_to_back();
        int accepts, acc_a, acc_b, rx_cnt, rx_a, rx_b;
        logic [7:0] d_a, d_b;
        accepts = 1; acc_b = -1; rx_cnt = 0; rx_a = -1; rx_b = -1; d_a = 8'h00; d_b = 8'h00;
        loop_mode = 1'b1;
        tx_valid = 1'b1; tx_data = 8'h11; tx_last = 1'b0;
        acc_a = cyc + 1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (rx_valid) begin
                rx_cnt++;
                if (rx_cnt == 1) begin rx_a = cyc - acc_a; d_a = rx_data; end
                else begin rx_b = cyc - acc_b; d_b = rx_data; end
            end
            if (accepts == 2 && cyc == acc_b) tx_valid = 1'b0;
            if (tx_valid && tx_ready) begin
                accepts++;
                if (accepts == 2) begin acc_b = cyc + 1; tx_data = 8'h96; tx_last = 1'b1; end
            end
        end
        tx_valid = 1'b0;
        checks++;
        if (accepts !== 2 || acc_b - acc_a !== 18) begin
            errors++; $display("FAIL b2b_accepts: got %0d accepts gap %0d, expected 2 gap 18", accepts, acc_b - acc_a);
        end
        checks++;
        if (rx_cnt !== 2 || rx_a !== 17 || rx_b !== 16 || d_a !== 8'h11 || d_b !== 8'h96) begin
            errors++;
            $display("FAIL b2b_rx: got %0d bytes %h@%0d %h@%0d, expected 2 11@17 96@16", rx_cnt, d_a, rx_a, d_b, rx_b);
        end
    endtask

    task automatic test_reset_mid_byte();
        int rises, acc, rx_at;
        logic prev, rx_seen;
        rises = 0; prev = 1'b0; rx_seen = 1'b0; rx_at = -1;
        loop_mode = 1'b1;
        tx_valid = 1'b1; tx_data = 8'hC3; tx_last = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int k = 0; k < 30 && rises < 4; k++) begin
            @(negedge clk);
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cs_n, sclk, busy, mosi, tx_ready} !== 5'b1_0_0_0_1 || rises !== 4) begin
            errors++;
            $display("FAIL midreset_async: got %b rises %0d, expected 10001 rises 4", {cs_n, sclk, busy, mosi, tx_ready}, rises);
        end
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (rx_valid) rx_seen = 1'b1;
        end
        checks++;
        if (rx_seen !== 1'b0) begin errors++; $display("FAIL midreset_no_rx: got %b, expected 0", rx_seen); end
        tx_valid = 1'b1; tx_data = 8'h3C; tx_last = 1'b1;
        @(negedge clk);
        acc = cyc;
        tx_valid = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (rx_valid && rx_at < 0) rx_at = cyc - acc;
        end
        checks++;
        if (rx_at !== 17 || rx_data !== 8'h3C || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_recover: got %h at %0d busy %b, expected 3c at 17 busy 0", rx_data, rx_at, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_frame();
        test_clkdiv3();
        test_back_to_back();
        test_reset_mid_byte();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
